keyboard_controller: RTL

- Memory-mapped PS/2 keyboard peripheral that sits on the keyboard port of the memory controller, in the CPU clock domain.
- Takes raw scancode bytes from the PS/2 receiver, already synchronized into this clock domain.
- Folds 0xE0 (extended) and 0xF0 (break) prefixes into a single key event.
- Buffers events in a FIFO and exposes data, status and control registers to the CPU.

---
 rtl/keyboard_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/keyboard_controller.sv
// PS/2 keyboard peripheral: folds E0/F0 prefixes into 10-bit key events, queues
// them in a FIFO and exposes DATA/STATUS/POP/CTRL words to the CPU bus.
module keyboard_controller #(
    parameter int DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scancode_valid_in,
    input  logic [7:0]  scancode_in,
    input  logic [31:0] cpu_addr_in,
    input  logic [31:0] cpu_data_in,
    input  logic [3:0]  cpu_write_enable_in,
    output logic [31:0] cpu_data_out,
    output logic        nonempty_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, EXT, REL, EXT_REL} dec_state_e;

    dec_state_e     state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           en_q, en_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [9:0]     mem_q [DEPTH];

    logic           we, pop_req, ctrl_wr, flush, is_e0, is_f0;
    logic           push, do_push, do_pop, ovf_set, empty, full;
    logic [9:0]     entry;
    logic           unused_bits;

    assign unused_bits = ^{cpu_addr_in[31:4], cpu_addr_in[1:0], cpu_data_in[31:3]};

    always_comb begin
        we      = |cpu_write_enable_in;
        pop_req = we && (cpu_addr_in[3:2] == 2'd2);
        ctrl_wr = we && (cpu_addr_in[3:2] == 2'd3);
        flush   = ctrl_wr && cpu_data_in[1];
        is_e0   = (scancode_in == 8'hE0);
        is_f0   = (scancode_in == 8'hF0);

        state_d = state_q;
        push    = 1'b0;
        entry   = {2'b00, scancode_in};
        // Disabled decoder sits in IDLE so a half-received prefix is dropped.
        if (!en_q) begin
            state_d = IDLE;
        end else if (scancode_valid_in) begin
            case (state_q)
                IDLE: begin
                    if (is_e0)      state_d = EXT;
                    else if (is_f0) state_d = REL;
                    else            push = 1'b1;
                end
                EXT: begin
                    if (is_f0) state_d = EXT_REL;
                    else if (!is_e0) begin
                        push     = 1'b1;
                        entry[8] = 1'b1;
                        state_d  = IDLE;
                    end
                end
                REL: begin
                    if (is_e0) state_d = EXT_REL;
                    else if (!is_f0) begin
                        push     = 1'b1;
                        entry[9] = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    if (!is_e0 && !is_f0) begin
                        push       = 1'b1;
                        entry[9:8] = 2'b11;
                        state_d    = IDLE;
                    end
                end
            endcase
        end

        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        // Flush dominates; a pop in the same cycle frees the slot a full-FIFO push needs.
        do_pop  = pop_req && !empty && !flush;
        do_push = push && !flush && (!full || do_pop);
        ovf_set = push && !flush && full && !do_pop;

        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
        count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
        en_d     = ctrl_wr ? cpu_data_in[0] : en_q;
        ovf_d    = ovf_q;
        if (ctrl_wr && cpu_data_in[2]) ovf_d = 1'b0;
        if (ovf_set)                   ovf_d = 1'b1;

        rdata_d = '0;
        case (cpu_addr_in[3:2])
            2'd0: if (!empty) rdata_d = 32'h8000_0000 | 32'(mem_q[rd_ptr_q]);
            2'd1: begin
                rdata_d[CW-1:0] = count_q;
                rdata_d[8]      = rdata_d[8] | empty;
                rdata_d[9]      = full;
                rdata_d[10]     = ovf_q;
                rdata_d[16]     = en_q;
            end
            2'd3: rdata_d[0] = en_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b1;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= entry;
    end

    assign cpu_data_out = rdata_q;
    assign nonempty_out = (count_q != '0);
endmodule
